// File: rtl/penalty_pkg.sv
// Shared types and helpers for the penalty shootout controller: result codes,
// FSM state encodings, field widths and saturating increments.
package penalty_pkg;

   localparam int SCORE_W = 3;
   localparam int KICK_W  = 4;

   typedef enum logic [1:0] {
      NONE       = 2'd0,
      PLAYER_WIN = 2'd1,
      ENEMY_WIN  = 2'd2,
      DRAW       = 2'd3
   } result_t;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE        = 3'd0;
   localparam state_t ST_PLAYER_TURN = 3'd1;
   localparam state_t ST_ENEMY_TURN  = 3'd2;
   localparam state_t ST_CHECK       = 3'd3;
   localparam state_t ST_DONE        = 3'd4;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [KICK_W-1:0]  KICK_MAX  = '1;

   function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
      return (v == SCORE_MAX) ? v : v + 3'd1;
   endfunction

   function automatic logic [KICK_W-1:0] sat_inc_kick(input logic [KICK_W-1:0] v);
      return (v == KICK_MAX) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/penalty_score_ctrl_if.sv
// Shot-event inputs and score/result outputs of the shootout controller.
// master = kick resolver / overlay side, slave = the controller.
interface penalty_score_ctrl_if;
   import penalty_pkg::*;

   logic                start;
   logic                shot_valid;
   logic                shot_goal;
   logic [SCORE_W-1:0]  score_player;
   logic [SCORE_W-1:0]  score_enemy;
   logic                turn;
   logic [KICK_W-1:0]   kick_round;
   logic                score_changed;
   logic                game_over;
   result_t             result;

   modport master (
      output start, shot_valid, shot_goal,
      input  score_player, score_enemy, turn, kick_round,
             score_changed, game_over, result
   );

   modport slave (
      input  start, shot_valid, shot_goal,
      output score_player, score_enemy, turn, kick_round,
             score_changed, game_over, result
   );

endinterface

// File: rtl/penalty_decide.sv
// Combinational match decision: maps scores and kick counts to a result.
// Regulation uses "can the trailing side still catch up"; sudden death compares pairs.
module penalty_decide
   import penalty_pkg::*;
#(
   parameter int MAX_KICKS = 5
) (
   input  logic [SCORE_W-1:0] sp,
   input  logic [SCORE_W-1:0] se,
   input  logic [KICK_W-1:0]  p_kicks,
   input  logic [KICK_W-1:0]  e_kicks,
   input  logic               sudden,
   input  logic               enemy_kicked,
   output result_t            decision
);

   localparam logic [KICK_W-1:0] MAX_K = KICK_W'(MAX_KICKS);

   logic [KICK_W-1:0] sp_w;
   logic [KICK_W-1:0] se_w;

   assign sp_w = {1'b0, sp};
   assign se_w = {1'b0, se};

   always_comb begin
      decision = NONE;
      if (sudden && (p_kicks > MAX_K)) begin
         // Only a completed pair can decide; a tie at the score ceiling is final.
         if (enemy_kicked) begin
            if (sp_w > se_w)
               decision = PLAYER_WIN;
            else if (se_w > sp_w)
               decision = ENEMY_WIN;
            else if (sp == SCORE_MAX)
               decision = DRAW;
         end
      end else begin
         if (sp_w > se_w + (MAX_K - e_kicks))
            decision = PLAYER_WIN;
         else if (se_w > sp_w + (MAX_K - p_kicks))
            decision = ENEMY_WIN;
         else if ((p_kicks == MAX_K) && (e_kicks == MAX_K) && !sudden)
            decision = DRAW;
      end
   end

endmodule

// File: rtl/penalty_score_ctrl.sv
// Penalty shootout sequencer and score registers.
// Optional sudden death after a regulation tie: define PENALTY_SUDDEN_DEATH_EN.
module penalty_score_ctrl
   import penalty_pkg::*;
#(
   parameter int MAX_KICKS = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   penalty_score_ctrl_if.slave  bus
);

`ifdef PENALTY_SUDDEN_DEATH_EN
   localparam logic SUDDEN = 1'b1;
`else
   localparam logic SUDDEN = 1'b0;
`endif

   state_t              state_reg;
   logic [SCORE_W-1:0]  score_player_reg;
   logic [SCORE_W-1:0]  score_enemy_reg;
   logic [KICK_W-1:0]   p_kicks_reg;
   logic [KICK_W-1:0]   e_kicks_reg;
   logic [KICK_W-1:0]   kick_round_reg;
   logic                turn_reg;
   logic                score_changed_reg;
   logic                game_over_reg;
   result_t             result_reg;
   result_t             decision;

   // In CHECK the turn has already flipped, so turn==0 means the enemy just kicked.
   penalty_decide #(
      .MAX_KICKS (MAX_KICKS)
   ) u_decide (
      .sp           (score_player_reg),
      .se           (score_enemy_reg),
      .p_kicks      (p_kicks_reg),
      .e_kicks      (e_kicks_reg),
      .sudden       (SUDDEN),
      .enemy_kicked (~turn_reg),
      .decision     (decision)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         score_player_reg  <= '0;
         score_enemy_reg   <= '0;
         p_kicks_reg       <= '0;
         e_kicks_reg       <= '0;
         kick_round_reg    <= '0;
         turn_reg          <= 1'b0;
         score_changed_reg <= 1'b0;
         game_over_reg     <= 1'b0;
         result_reg        <= NONE;
      end else if (bus.start) begin
         state_reg         <= ST_PLAYER_TURN;
         score_player_reg  <= '0;
         score_enemy_reg   <= '0;
         p_kicks_reg       <= '0;
         e_kicks_reg       <= '0;
         kick_round_reg    <= 4'd1;
         turn_reg          <= 1'b0;
         score_changed_reg <= 1'b0;
         game_over_reg     <= 1'b0;
         result_reg        <= NONE;
      end else begin
         score_changed_reg <= 1'b0;
         case (state_reg)
            ST_PLAYER_TURN: begin
               if (bus.shot_valid) begin
                  p_kicks_reg <= sat_inc_kick(p_kicks_reg);
                  if (bus.shot_goal) begin
                     score_player_reg  <= sat_inc_score(score_player_reg);
                     score_changed_reg <= (score_player_reg != SCORE_MAX);
                  end
                  turn_reg  <= 1'b1;
                  state_reg <= ST_CHECK;
               end
            end
            ST_ENEMY_TURN: begin
               if (bus.shot_valid) begin
                  e_kicks_reg <= sat_inc_kick(e_kicks_reg);
                  if (bus.shot_goal) begin
                     score_enemy_reg   <= sat_inc_score(score_enemy_reg);
                     score_changed_reg <= (score_enemy_reg != SCORE_MAX);
                  end
                  turn_reg  <= 1'b0;
                  state_reg <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (decision != NONE) begin
                  result_reg    <= decision;
                  game_over_reg <= 1'b1;
                  state_reg     <= ST_DONE;
               end else if (!turn_reg) begin
                  kick_round_reg <= sat_inc_kick(kick_round_reg);
                  state_reg      <= ST_PLAYER_TURN;
               end else begin
                  state_reg <= ST_ENEMY_TURN;
               end
            end
            ST_DONE:  state_reg <= ST_DONE;
            default:  state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.score_player  = score_player_reg;
   assign bus.score_enemy   = score_enemy_reg;
   assign bus.turn          = turn_reg;
   assign bus.kick_round    = kick_round_reg;
   assign bus.score_changed = score_changed_reg;
   assign bus.game_over     = game_over_reg;
   assign bus.result        = result_reg;

endmodule

// File: tb/tb_penalty_score_ctrl.sv
// Self-checking bench for penalty_score_ctrl: decision table, directed match
// sequences, randomized matches against a per-kick reference model, MAX_KICKS=1 build.
module tb_penalty_score_ctrl;
   import penalty_pkg::*;

   localparam int MAXK = 5;
`ifdef PENALTY_SUDDEN_DEATH_EN
   localparam bit SD = 1'b1;
`else
   localparam bit SD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   penalty_score_ctrl_if if0 ();
   penalty_score_ctrl_if if1 ();

   penalty_score_ctrl #(.MAX_KICKS(MAXK)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   penalty_score_ctrl #(.MAX_KICKS(1))    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   logic [2:0] d_sp, d_se;
   logic [3:0] d_pk, d_ek;
   logic       d_sudden, d_enemy;
   result_t    d_res;

   penalty_decide #(.MAX_KICKS(MAXK)) u_dec (
      .sp(d_sp), .se(d_se), .p_kicks(d_pk), .e_kicks(d_ek),
      .sudden(d_sudden), .enemy_kicked(d_enemy), .decision(d_res)
   );

   typedef struct {
      logic [2:0] sp, se;
      logic [3:0] pk, ek;
      logic       sudden, enemy;
      result_t    exp;
   } dec_vec_t;

   dec_vec_t vec [14];

   int checks = 0;
   int errors = 0;

   // Reference model: raw goal/kick tallies of the current match.
   int m_phase;        // 0 idle, 1 playing, 2 decided
   bit m_enemy_next;
   int m_gp, m_ge, m_pk, m_ek, m_res;

   function automatic int min_i(int a, int b);
      return (a < b) ? a : b;
   endfunction

   // Decided once the leader is out of reach of the other side's remaining kicks.
   function automatic int model_decide(int gp, int ge, int pk_raw, int ek_raw,
                                       bit enemy_kicked, bit sd);
      int sp = min_i(gp, 7);
      int se = min_i(ge, 7);
      int pk = min_i(pk_raw, 15);
      int ek = min_i(ek_raw, 15);
      if (pk <= MAXK && ek <= MAXK) begin
         if (sp > se + (MAXK - ek)) return 1;
         if (se > sp + (MAXK - pk)) return 2;
         if (pk == MAXK && ek == MAXK) return sd ? 0 : 3;
         return 0;
      end
      if (!enemy_kicked) return 0;
      if (sp > se) return 1;
      if (se > sp) return 2;
      return (sp == 7) ? 3 : 0;
   endfunction

   function automatic int exp_round();
      if (m_phase == 0) return 0;
      if (m_phase == 2 || m_enemy_next) return min_i(m_pk, 15);
      return min_i(m_ek + 1, 15);
   endfunction

   task automatic model_clear(int phase);
      m_phase = phase; m_enemy_next = 1'b0;
      m_gp = 0; m_ge = 0; m_pk = 0; m_ek = 0; m_res = 0;
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(string tag);
      chk({tag, ".score_player"}, int'(if0.score_player), min_i(m_gp, 7));
      chk({tag, ".score_enemy"},  int'(if0.score_enemy),  min_i(m_ge, 7));
      chk({tag, ".turn"},         int'(if0.turn),         int'(m_enemy_next));
      chk({tag, ".kick_round"},   int'(if0.kick_round),   exp_round());
      chk({tag, ".score_changed"},int'(if0.score_changed),0);
      chk({tag, ".game_over"},    int'(if0.game_over),    (m_phase == 2) ? 1 : 0);
      chk({tag, ".result"},       int'(if0.result),       m_res);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear(0);
      chk_state("reset");
      $display("reset");
   endtask

   task automatic do_start(bit with_shot);
      if0.start = 1'b1;
      if0.shot_valid = with_shot;
      if0.shot_goal = 1'b1;
      tick();
      if0.start = 1'b0;
      if0.shot_valid = 1'b0;
      model_clear(1);
      chk_state("start");
      $display("start shot=%0d", with_shot);
   endtask

   task automatic kick(bit goal);
      int  old_round;
      int  old_sp, old_se, chg;
      bit  player;
      old_round = exp_round();
      old_sp = min_i(m_gp, 7);
      old_se = min_i(m_ge, 7);
      player = !m_enemy_next;
      if0.shot_valid = 1'b1;
      if0.shot_goal = goal;
      tick();
      if0.shot_valid = 1'b0;
      if (m_phase != 1) begin
         chk_state("ignored_shot");
         $display("shot ignored goal=%0d", goal);
         return;
      end
      chg = (goal && (player ? old_sp < 7 : old_se < 7)) ? 1 : 0;
      if (player) begin m_pk++; if (goal) m_gp++; end
      else        begin m_ek++; if (goal) m_ge++; end
      m_enemy_next = !m_enemy_next;
      chk("shot.score_player",  int'(if0.score_player),  min_i(m_gp, 7));
      chk("shot.score_enemy",   int'(if0.score_enemy),   min_i(m_ge, 7));
      chk("shot.turn",          int'(if0.turn),          int'(m_enemy_next));
      chk("shot.score_changed", int'(if0.score_changed), chg);
      chk("shot.kick_round",    int'(if0.kick_round),    old_round);
      chk("shot.game_over",     int'(if0.game_over),     0);
      // The decision cycle must ignore another shot.
      if0.shot_valid = 1'($urandom_range(0, 1));
      if0.shot_goal = 1'b1;
      tick();
      if0.shot_valid = 1'b0;
      m_res = model_decide(m_gp, m_ge, m_pk, m_ek, !player, SD);
      if (m_res != 0) m_phase = 2;
      chk_state("decide");
      $display("kick %s goal=%0d score %0d:%0d round %0d result %0d",
               player ? "player" : "enemy", goal, min_i(m_gp, 7), min_i(m_ge, 7),
               exp_round(), m_res);
   endtask

   initial begin
      int p, n, chg_cnt;
      if0.start = 1'b0; if0.shot_valid = 1'b0; if0.shot_goal = 1'b0;
      if1.start = 1'b0; if1.shot_valid = 1'b0; if1.shot_goal = 1'b0;

      // Decision table (MAX_KICKS = 5): sp se pk ek sudden enemy_kicked -> result
      vec[0]  = '{3'd3, 3'd0, 4'd3, 4'd3, 1'b0, 1'b1, PLAYER_WIN};
      vec[1]  = '{3'd3, 3'd0, 4'd3, 4'd2, 1'b0, 1'b0, NONE};
      vec[2]  = '{3'd0, 3'd3, 4'd3, 4'd3, 1'b0, 1'b1, ENEMY_WIN};
      vec[3]  = '{3'd5, 3'd5, 4'd5, 4'd5, 1'b0, 1'b1, DRAW};
      vec[4]  = '{3'd5, 3'd5, 4'd5, 4'd5, 1'b1, 1'b1, NONE};
      vec[5]  = '{3'd6, 3'd5, 4'd6, 4'd5, 1'b1, 1'b0, NONE};
      vec[6]  = '{3'd6, 3'd5, 4'd6, 4'd6, 1'b1, 1'b1, PLAYER_WIN};
      vec[7]  = '{3'd5, 3'd6, 4'd6, 4'd6, 1'b1, 1'b1, ENEMY_WIN};
      vec[8]  = '{3'd7, 3'd7, 4'd8, 4'd8, 1'b1, 1'b1, DRAW};
      vec[9]  = '{3'd6, 3'd6, 4'd6, 4'd6, 1'b1, 1'b1, NONE};
      vec[10] = '{3'd1, 3'd0, 4'd1, 4'd0, 1'b0, 1'b0, NONE};
      vec[11] = '{3'd4, 3'd2, 4'd5, 4'd4, 1'b0, 1'b0, PLAYER_WIN};
      vec[12] = '{3'd2, 3'd4, 4'd4, 4'd5, 1'b0, 1'b1, ENEMY_WIN};
      vec[13] = '{3'd0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1, NONE};
      for (int i = 0; i < 14; i++) begin
         d_sp = vec[i].sp; d_se = vec[i].se; d_pk = vec[i].pk; d_ek = vec[i].ek;
         d_sudden = vec[i].sudden; d_enemy = vec[i].enemy;
         #1;
         chk($sformatf("decide_vec%0d", i), int'(d_res), int'(vec[i].exp));
         $display("decide vec %0d -> %0d", i, int'(d_res));
      end

      // Reset state and shots ignored while idle.
      do_reset();
      kick(1'b1);

      // Player scores every kick, enemy misses every kick.
      do_start(1'b0);
      for (int i = 0; i < 10 && m_phase == 1; i++) kick((i % 2) == 0);
      chk("pwin.game_over",  int'(if0.game_over),  1);
      chk("pwin.result",     int'(if0.result),     int'(PLAYER_WIN));
      chk("pwin.score",      int'({if0.score_player, if0.score_enemy}), int'({3'd3, 3'd0}));
      chk("pwin.kick_round", int'(if0.kick_round), 3);
      kick(1'b1);
      kick(1'b1);

      // All ten regulation kicks are goals.
      do_start(1'b0);
      for (int i = 0; i < 10; i++) kick(1'b1);
      if (SD) begin
         chk("tie.game_over", int'(if0.game_over), 0);
         kick(1'b1);
         kick(1'b0);
         chk("sd.result", int'(if0.result), int'(PLAYER_WIN));
         chk("sd.score",  int'({if0.score_player, if0.score_enemy}), int'({3'd6, 3'd5}));
      end else begin
         chk("tie.result", int'(if0.result), int'(DRAW));
         chk("tie.score",  int'({if0.score_player, if0.score_enemy}), int'({3'd5, 3'd5}));
      end

      // start together with shot_valid mid-match at 2:1.
      do_start(1'b0);
      kick(1'b1); kick(1'b1); kick(1'b1);
      do_start(1'b1);
      chk("restart.score", int'({if0.score_player, if0.score_enemy}), 0);
      chk("restart.round", int'(if0.kick_round), 1);

      // rst at 3:2 during the enemy's turn.
      do_start(1'b0);
      for (int i = 0; i < 5; i++) kick(1'b1);
      do_reset();
      kick(1'b1);
      kick(1'b0);

      // Randomized matches with varying goal rates and idle gaps.
      for (int m = 0; m < 25; m++) begin
         do_start(1'b0);
         p = $urandom_range(20, 80);
         for (int k = 0; k < 40 && m_phase == 1; k++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin tick(); chk_state("idle_gap"); end
            kick($urandom_range(0, 99) < p);
         end
      end

      // MAX_KICKS = 1: player goal, enemy miss.
      chg_cnt = 0;
      if1.start = 1'b1; tick(); if1.start = 1'b0;
      chk("k1.round", int'(if1.kick_round), 1);
      if1.shot_valid = 1'b1; if1.shot_goal = 1'b1; tick(); if1.shot_valid = 1'b0;
      chg_cnt += int'(if1.score_changed);
      tick(); chg_cnt += int'(if1.score_changed);
      chk("k1.after_player.game_over", int'(if1.game_over), 0);
      if1.shot_valid = 1'b1; if1.shot_goal = 1'b0; tick(); if1.shot_valid = 1'b0;
      chg_cnt += int'(if1.score_changed);
      tick(); chg_cnt += int'(if1.score_changed);
      chk("k1.game_over", int'(if1.game_over), 1);
      chk("k1.result",    int'(if1.result),    int'(PLAYER_WIN));
      chk("k1.score",     int'({if1.score_player, if1.score_enemy}), int'({3'd1, 3'd0}));
      repeat (3) begin tick(); chg_cnt += int'(if1.score_changed); end
      chk("k1.score_changed_count", chg_cnt, 1);
      $display("max_kicks=1 match result %0d", int'(if1.result));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
